// File: rtl/spi_slv_pkg.sv
`timescale 1ns/1ps
// Register map, bit positions and reset values shared by the SPI slave and its bench.
package spi_slv_pkg;
  localparam logic [3:0]  SPI_SLV_REG_STATUS = 4'h0;
  localparam logic [3:0]  SPI_SLV_REG_CTRL   = 4'h4;
  localparam logic [3:0]  SPI_SLV_REG_TX     = 4'h8;
  localparam logic [3:0]  SPI_SLV_REG_RX     = 4'hC;

  localparam int SPI_SLV_REG_CTRL_CPOL   = 0;
  localparam int SPI_SLV_REG_CTRL_CPHA   = 1;
  localparam int SPI_SLV_REG_CTRL_EN     = 8;
  localparam int SPI_SLV_REG_CTRL_IRQ_EN = 9;

  localparam int SPI_SLV_REG_STAT_RX_NE    = 0;
  localparam int SPI_SLV_REG_STAT_TX_EMPTY = 1;
  localparam int SPI_SLV_REG_STAT_BUSY     = 2;
  localparam int SPI_SLV_REG_STAT_OVERRUN  = 3;
  localparam int SPI_SLV_REG_STAT_UNDERRUN = 4;
  localparam int SPI_SLV_REG_STAT_LVL_LSB  = 8;

  localparam logic [31:0] SPI_SLV_REG_CTRL_RST = 32'h0000_0100;

  typedef enum logic [1:0] {REG_STATUS, REG_CTRL, REG_TX, REG_RX} reg_sel_e;

  // Word-aligned decode: byte offset bits are ignored.
  function automatic reg_sel_e reg_sel(input logic [3:0] addr);
    return reg_sel_e'(addr[3:2]);
  endfunction
endpackage

// File: rtl/spi_slave_mmio_if.sv
`timescale 1ns/1ps
// Memory-mapped register bus plus interrupt line between a host and the SPI slave.
interface mmio_if;
  logic        mmio_valid;
  logic        mmio_we;
  logic [7:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [3:0]  mmio_wstrb;
  logic [31:0] mmio_rdata;
  logic        mmio_ready;
  logic        irq_o;

  modport master (
    output mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb,
    input  mmio_rdata, mmio_ready, irq_o
  );
  modport slave (
    input  mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb,
    output mmio_rdata, mmio_ready, irq_o
  );
endinterface

// File: rtl/spi_slv_fifo.sv
`timescale 1ns/1ps
// Synchronous FIFO with occupancy output; a pop frees a slot for a same-cycle push.
module spi_slv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/spi_slave_mmio.sv
`timescale 1ns/1ps
// SPI slave (modes 0-3, 8-bit MSB-first) with MMIO registers and an RX FIFO.
// Optional: define SPI_SLV_IRQ_EN for a registered interrupt on irq_o.
module spi_slave_mmio
  import spi_slv_pkg::*;
#(
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  spi_sclk,
  input  logic  spi_cs_n,
  input  logic  spi_mosi,
  output logic  spi_miso,
  output logic  spi_miso_oe,
  mmio_if.slave mmio
);
  localparam int LW = $clog2(RX_DEPTH) + 1;

  // {mosi, cs_n, sclk}; idle is CS high, SCLK low
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{3'b010}};
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sync_q[0] <= {spi_mosi, spi_cs_n, spi_sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end
  assign {mosi_s, cs_s, sclk_s} = sync_q[SYNC_STAGES-1];

  reg_sel_e sel;
  logic wr, rd, ctrl_wr, tx_wr, stat_wr, rx_pop;
  logic cpol, cpha, en, irq_en;

  assign sel     = reg_sel(mmio.mmio_addr[3:0]);
  assign wr      = mmio.mmio_valid & mmio.mmio_we;
  assign rd      = mmio.mmio_valid & ~mmio.mmio_we;
  assign ctrl_wr = wr & (sel == REG_CTRL);
  assign tx_wr   = wr & (sel == REG_TX) & mmio.mmio_wstrb[0];
  assign stat_wr = wr & (sel == REG_STATUS) & mmio.mmio_wstrb[0];
  assign rx_pop  = rd & (sel == REG_RX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol <= SPI_SLV_REG_CTRL_RST[SPI_SLV_REG_CTRL_CPOL];
      cpha <= SPI_SLV_REG_CTRL_RST[SPI_SLV_REG_CTRL_CPHA];
      en   <= SPI_SLV_REG_CTRL_RST[SPI_SLV_REG_CTRL_EN];
    end else if (ctrl_wr) begin
      if (mmio.mmio_wstrb[0]) begin
        cpol <= mmio.mmio_wdata[SPI_SLV_REG_CTRL_CPOL];
        cpha <= mmio.mmio_wdata[SPI_SLV_REG_CTRL_CPHA];
      end
      if (mmio.mmio_wstrb[1]) en <= mmio.mmio_wdata[SPI_SLV_REG_CTRL_EN];
    end
  end

`ifdef SPI_SLV_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_en <= SPI_SLV_REG_CTRL_RST[SPI_SLV_REG_CTRL_IRQ_EN];
    else if (ctrl_wr && mmio.mmio_wstrb[1]) irq_en <= mmio.mmio_wdata[SPI_SLV_REG_CTRL_IRQ_EN];
  end
`else
  assign irq_en = 1'b0;
`endif

  logic act, cs_fall, cs_rise, lead, trail, smp, shf, tx_load, defer;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] tx_sh, tx_hold, push_data;
  logic       tx_empty, und_pend, push_vld, ovr, und, ovr_set, und_set;
  logic [7:0] fifo_dout;
  logic [LW-1:0] level;
  logic       full, empty;

  assign act     = en & ~cs_s;
  assign cs_fall = en & cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
  assign lead    = cpol ? (sclk_d & ~sclk_s) : (sclk_s & ~sclk_d);
  assign trail   = cpol ? (sclk_s & ~sclk_d) : (sclk_d & ~sclk_s);
  assign smp     = act & (cpha ? trail : lead);
  assign shf     = act & (cpha ? lead : trail);

  // CPHA=0 also reloads on the shift edge that ends a byte, which happens even
  // when CS is about to rise; its underrun only counts once the next byte samples.
  assign defer   = ~cpha & shf & (bit_cnt == 3'd0);
  assign tx_load = (~cpha & cs_fall) | (shf & (bit_cnt == 3'd0));
  assign und_set = (tx_load & tx_empty & ~defer) | (und_pend & smp);
  assign ovr_set = push_vld & full & ~rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      push_vld  <= 1'b0;
      push_data <= '0;
      und_pend  <= 1'b0;
    end else begin
      push_vld <= smp & (bit_cnt == 3'd7);
      if (smp) push_data <= {rx_sh, mosi_s};
      if (cs_fall || cs_rise) bit_cnt <= '0;
      else if (smp) begin
        rx_sh   <= {rx_sh[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (cs_rise || smp) und_pend <= 1'b0;
      else if (defer && tx_empty) und_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh    <= 8'hFF;
      tx_hold  <= '0;
      tx_empty <= 1'b1;
      ovr      <= 1'b0;
      und      <= 1'b0;
    end else begin
      if (tx_load) tx_sh <= tx_empty ? 8'hFF : tx_hold;
      else if (shf) tx_sh <= {tx_sh[6:0], 1'b1};
      if (tx_wr) begin
        tx_hold  <= mmio.mmio_wdata[7:0];
        tx_empty <= 1'b0;
      end else if (tx_load) tx_empty <= 1'b1;
      ovr <= ovr_set | (ovr & ~(stat_wr & mmio.mmio_wdata[SPI_SLV_REG_STAT_OVERRUN]));
      und <= und_set | (und & ~(stat_wr & mmio.mmio_wdata[SPI_SLV_REG_STAT_UNDERRUN]));
    end
  end

  spi_slv_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_vld),
    .din   (push_data),
    .pop   (rx_pop),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    mmio.mmio_rdata = '0;
    case (sel)
      REG_STATUS: begin
        mmio.mmio_rdata[SPI_SLV_REG_STAT_RX_NE]    = ~empty;
        mmio.mmio_rdata[SPI_SLV_REG_STAT_TX_EMPTY] = tx_empty;
        mmio.mmio_rdata[SPI_SLV_REG_STAT_BUSY]     = ~cs_s;
        mmio.mmio_rdata[SPI_SLV_REG_STAT_OVERRUN]  = ovr;
        mmio.mmio_rdata[SPI_SLV_REG_STAT_UNDERRUN] = und;
        mmio.mmio_rdata[SPI_SLV_REG_STAT_LVL_LSB +: 4] = 4'(level);
      end
      REG_CTRL: begin
        mmio.mmio_rdata[SPI_SLV_REG_CTRL_CPOL]   = cpol;
        mmio.mmio_rdata[SPI_SLV_REG_CTRL_CPHA]   = cpha;
        mmio.mmio_rdata[SPI_SLV_REG_CTRL_EN]     = en;
        mmio.mmio_rdata[SPI_SLV_REG_CTRL_IRQ_EN] = irq_en;
      end
      REG_RX:  mmio.mmio_rdata[7:0] = empty ? 8'h00 : fifo_dout;
      default: ;
    endcase
  end

`ifdef SPI_SLV_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_en & (~empty | ovr | und);
  end
  assign mmio.irq_o = irq_q;
`else
  assign mmio.irq_o = 1'b0;
`endif

  assign mmio.mmio_ready = 1'b1;
  assign spi_miso        = tx_sh[7];
  assign spi_miso_oe     = en & ~cs_s;

  logic unused_bits;
  assign unused_bits = ^{mmio.mmio_addr[7:4], mmio.mmio_addr[1:0],
                         mmio.mmio_wdata[31:9], mmio.mmio_wstrb[3:2]};
endmodule

// File: tb/tb_spi_slave_mmio.sv
`timescale 1ns/1ps
// Directed bench for spi_slave_mmio: table of single-byte frames in all modes plus corner sequences.
module tb_spi_slave_mmio;
  import spi_slv_pkg::*;

  localparam int H = 80;
  localparam logic [7:0] A_STAT = 8'(SPI_SLV_REG_STATUS);
  localparam logic [7:0] A_CTRL = 8'(SPI_SLV_REG_CTRL);
  localparam logic [7:0] A_TX   = 8'(SPI_SLV_REG_TX);
  localparam logic [7:0] A_RX   = 8'(SPI_SLV_REG_RX);

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, oe;
  int checks = 0, errors = 0;

  mmio_if bus();

  spi_slave_mmio #(.RX_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (sclk),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (oe),
    .mmio        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    @(negedge clk);
    bus.mmio_valid = 1'b1; bus.mmio_we = 1'b1;
    bus.mmio_addr = a; bus.mmio_wdata = d; bus.mmio_wstrb = s;
    @(posedge clk); #1;
    bus.mmio_valid = 1'b0; bus.mmio_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.mmio_valid = 1'b1; bus.mmio_we = 1'b0; bus.mmio_addr = a;
    #1 d = bus.mmio_rdata;
    @(posedge clk); #1;
    bus.mmio_valid = 1'b0;
  endtask

  task automatic rchk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  // SPI master: n bits MSB first from tx[n-1:0]; miso collected at the master sample edge.
  task automatic spi_frame(input logic cpol, input logic cpha, input logic [31:0] tx, input int n,
                           output logic [31:0] rx, output logic oe_or, output logic oe_and);
    rx = '0; oe_or = 1'b0; oe_and = 1'b1;
    @(negedge clk);
    sclk = cpol;
    #(H) cs_n = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = tx[i];
        #(H) sclk = ~cpol;
        rx = {rx[30:0], miso}; oe_or |= oe; oe_and &= oe;
        #(H) sclk = cpol;
      end else begin
        #(H) sclk = ~cpol;
        mosi = tx[i];
        #(H) sclk = cpol;
        rx = {rx[30:0], miso}; oe_or |= oe; oe_and &= oe;
      end
    end
    #(H) cs_n = 1'b1;
    #(H);
  endtask

  typedef struct {
    logic [1:0]  mode;      // {CPOL, CPHA}
    logic [7:0]  tx;
    logic [7:0]  mosi;
    logic [7:0]  exp_miso;
    logic [7:0]  exp_rx;
    logic [31:0] exp_stat;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete (checks %0d)", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v[4];
    logic [31:0] r;
    logic o_or, o_and;

    v[0] = '{2'b00, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 32'h0000_0103};
    v[1] = '{2'b01, 8'hC3, 8'h96, 8'hC3, 8'h96, 32'h0000_0103};
    v[2] = '{2'b10, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 32'h0000_0103};
    v[3] = '{2'b11, 8'h81, 8'h7E, 8'h81, 8'h7E, 32'h0000_0103};

    bus.mmio_valid = 1'b0; bus.mmio_we = 1'b0; bus.mmio_addr = '0;
    bus.mmio_wdata = '0; bus.mmio_wstrb = '0;

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("reset miso", 32'(miso), 32'd1);
    chk("reset oe", 32'(oe), 32'd0);
    chk("reset irq", 32'(bus.irq_o), 32'd0);
    chk("reset ready", 32'(bus.mmio_ready), 32'd1);
    rchk("reset status", A_STAT, 32'h0000_0002);
    rchk("reset ctrl", A_CTRL, 32'h0000_0100);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // one byte per mode
    for (int i = 0; i < 4; i++) begin
      wr(A_STAT, 32'h18);
      wr(A_CTRL, 32'h100 | 32'({v[i].mode[0], v[i].mode[1]}));
      wr(A_TX, 32'(v[i].tx));
      spi_frame(v[i].mode[1], v[i].mode[0], 32'(v[i].mosi), 8, r, o_or, o_and);
      chk($sformatf("vec%0d miso", i), r, 32'(v[i].exp_miso));
      chk($sformatf("vec%0d oe", i), 32'(o_and), 32'd1);
      rchk($sformatf("vec%0d status", i), A_STAT, v[i].exp_stat);
      rchk($sformatf("vec%0d rx", i), A_RX, 32'(v[i].exp_rx));
      rchk($sformatf("vec%0d status after pop", i), A_STAT, 32'h0000_0002);
    end

    // wstrb handling on CTRL and TX, TX overwrite
    wr(A_CTRL, 32'h0000_0000, 4'b0001);
    rchk("ctrl strb0 only", A_CTRL, 32'h0000_0100);
    wr(A_TX, 32'h77, 4'b0010);
    rchk("tx no strb0", A_STAT, 32'h0000_0002);
    wr(A_TX, 32'h11);
    wr(A_TX, 32'h22);
    rchk("tx holding full", A_STAT, 32'h0000_0000);
    spi_frame(1'b0, 1'b0, 32'h00, 8, r, o_or, o_and);
    chk("tx overwrite miso", r, 32'h22);
    rchk("tx overwrite rx", A_RX, 32'h00);

    // mode 3, no TX data: two 0xFF bytes and underrun, then W1C
    wr(A_CTRL, 32'h103);
    spi_frame(1'b1, 1'b1, 32'hC35A, 16, r, o_or, o_and);
    chk("underrun miso", r, 32'hFFFF);
    rchk("underrun status", A_STAT, 32'h0000_0213);
    wr(A_STAT, 32'h10);
    rchk("underrun w1c", A_STAT, 32'h0000_0203);
    rchk("underrun rx0", A_RX, 32'hC3);
    rchk("underrun rx1", A_RX, 32'h5A);

    // mode 0 back-to-back: second byte finds the holding register empty
    wr(A_CTRL, 32'h100);
    wr(A_TX, 32'h5A);
    spi_frame(1'b0, 1'b0, 32'h1234, 16, r, o_or, o_and);
    chk("b2b miso", r, 32'h5AFF);
    rchk("b2b status", A_STAT, 32'h0000_0213);
    rchk("b2b rx0", A_RX, 32'h12);
    rchk("b2b rx1", A_RX, 32'h34);
    wr(A_STAT, 32'h18);

    // overflow: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) spi_frame(1'b0, 1'b0, 32'(i * 8'h11), 8, r, o_or, o_and);
    rchk("ovf status", A_STAT, 32'h0000_041B);
    for (int i = 1; i <= 4; i++) rchk($sformatf("ovf rx%0d", i), A_RX, 32'(i * 8'h11));
    rchk("ovf empty read", A_RX, 32'h00);
    rchk("ovf status drained", A_STAT, 32'h0000_001A);
    wr(A_STAT, 32'h18);
    rchk("ovf w1c", A_STAT, 32'h0000_0002);

    // partial frame aborted by CS, then a full 0x81 frame
    wr(A_TX, 32'h00);
    spi_frame(1'b0, 1'b0, 32'h1F, 5, r, o_or, o_and);
    wr(A_TX, 32'h12);
    spi_frame(1'b0, 1'b0, 32'h81, 8, r, o_or, o_and);
    chk("abort miso", r, 32'h12);
    rchk("abort status", A_STAT, 32'h0000_0103);
    rchk("abort rx", A_RX, 32'h81);

    // EN=0 ignores the bus
    wr(A_CTRL, 32'h000);
    spi_frame(1'b0, 1'b0, 32'h99, 8, r, o_or, o_and);
    chk("disabled oe", 32'(o_or), 32'd0);
    rchk("disabled status", A_STAT, 32'h0000_0002);
    rchk("disabled ctrl", A_CTRL, 32'h0000_0000);

`ifdef SPI_SLV_IRQ_EN
    wr(A_CTRL, 32'h300);
    rchk("irq ctrl", A_CTRL, 32'h0000_0300);
    chk("irq idle", 32'(bus.irq_o), 32'd0);
    wr(A_TX, 32'h42);
    spi_frame(1'b0, 1'b0, 32'h24, 8, r, o_or, o_and);
    chk("irq set", 32'(bus.irq_o), 32'd1);
    rchk("irq rx", A_RX, 32'h24);
    @(posedge clk); #1;
    chk("irq cleared", 32'(bus.irq_o), 32'd0);
`else
    wr(A_CTRL, 32'h300);
    rchk("irq ctrl", A_CTRL, 32'h0000_0100);
    wr(A_TX, 32'h42);
    spi_frame(1'b0, 1'b0, 32'h24, 8, r, o_or, o_and);
    chk("irq tied", 32'(bus.irq_o), 32'd0);
    rchk("irq rx", A_RX, 32'h24);
`endif
    wr(A_CTRL, 32'h100);

    // reset mid-frame
    spi_frame(1'b0, 1'b0, 32'h55, 8, r, o_or, o_and);
    rchk("pre-reset status", A_STAT, 32'h0000_0113);
    wr(A_TX, 32'hE7);
    wr(A_CTRL, 32'h103);
    @(negedge clk) sclk = 1'b1;
    #(H) cs_n = 1'b0;
    #(H) sclk = 1'b0;
    #(H) sclk = 1'b1;
    #(H) sclk = 1'b0;
    #(H);
    chk("mid-frame oe", 32'(oe), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst miso", 32'(miso), 32'd1);
    chk("midrst oe", 32'(oe), 32'd0);
    chk("midrst irq", 32'(bus.irq_o), 32'd0);
    rchk("midrst ctrl", A_CTRL, 32'h0000_0100);
    rchk("midrst status", A_STAT, 32'h0000_0002);
    cs_n = 1'b1; sclk = 1'b0;
    #(H);
    @(negedge clk) rst_n = 1'b1;
    #(H);
    wr(A_TX, 32'h9C);
    spi_frame(1'b0, 1'b0, 32'h6B, 8, r, o_or, o_and);
    chk("post-reset miso", r, 32'h9C);
    rchk("post-reset status", A_STAT, 32'h0000_0103);
    rchk("post-reset rx", A_RX, 32'h6B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_mmio.md
SPI_SLAVE_MMIO -- requirements
Module: spi_slave_mmio

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, RX FIFO depth in bytes (power of 2, ≥2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per SPI input.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic is on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port spi_sclk, input, 1, SCLK from the external master, asynchronous to clk.
REQ-006 SHALL have port spi_cs_n, input, 1, active-low chip select from the external master, asynchronous to clk.
REQ-007 SHALL have port spi_mosi, input, 1, serial data from the master.
REQ-008 SHALL have port spi_miso, output, 1, serial data to the master.
REQ-009 SHALL have port spi_miso_oe, output, 1, MISO drive enable; high only while synchronized CS is low and EN=1.
REQ-010 SHALL have port mmio, mmio_if.slave, -, carrying mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb, mmio_rdata, mmio_ready and irq_o.

Function
REQ-011 SHALL tie mmio_ready to 1, so every valid is accepted in one cycle; reads SHALL be combinational and word-aligned (addr[1:0] ignored).
REQ-012 SHALL implement these registers: STATUS 0x00 (RO except W1C bits); CTRL 0x04 (bit0 CPOL, bit1 CPHA, bit8 EN, bit9 IRQ_EN); TX 0x08 (WO, byte [7:0]); RX 0x0C (RO, pop).
REQ-013 SHALL honour mmio_wstrb on CTRL; writes to TX SHALL require wstrb[0]=1.
REQ-014 STATUS bits SHALL be: 0 RX_NE, 1 TX_EMPTY (holding register free), 2 BUSY (synchronized CS low), 3 OVERRUN (W1C), 4 UNDERRUN (W1C), [11:8] RX level.
REQ-015 SHALL pass SCLK, CS_n and MOSI through SYNC_STAGES flops and edge-detect the synchronized SCLK and CS_n; supported SCLK ≤ clk/8.
REQ-016 Sample edge SHALL be the leading SCLK edge when CPHA=0 and the trailing edge when CPHA=1; leading edge is rising when CPOL=0 and falling when CPOL=1. The shift edge SHALL be the opposite edge.
REQ-017 Frames SHALL be 8 bits, MSB first; a 3-bit counter SHALL reset on the CS falling edge.
REQ-018 On the CS falling edge (CPHA=0) or first leading edge (CPHA=1), the TX shift register SHALL load the holding byte and set TX_EMPTY; if already empty, it SHALL load 0xFF and set UNDERRUN.
REQ-019 After the 8th sample, the assembled byte SHALL be pushed to the RX FIFO on the next clk; if the FIFO is full, the byte SHALL be dropped and OVERRUN set. The next TX byte SHALL load per REQ-018 for back-to-back frames.
REQ-020 CS rising mid-frame SHALL discard the partial byte, reset the bit counter, and not push or set flags.
REQ-021 An RX read when empty SHALL return 0 and not change pointers; a push and a pop in the same cycle SHALL leave the level unchanged.
REQ-022 A TX write while TX_EMPTY=0 SHALL overwrite the holding byte; a write coinciding with a load SHALL be taken as the next byte.
REQ-023 With EN=0, the block SHALL ignore SPI edges, drive spi_miso_oe=0 and hold the FIFO contents.
REQ-024 spi_miso SHALL present the TX shift MSB and change only on the shift edge (CPHA=0 first bit at CS fall).

Reset
REQ-025 On rst_n low: CTRL=0x0000_0100, FIFO empty, TX_EMPTY=1, OVERRUN=UNDERRUN=0, spi_miso=1, spi_miso_oe=0, irq_o=0, synchronizers set to idle (CS_n=1, SCLK=CPOL reset 0).

Configuration
REQ-026 With SPI_SLV_IRQ_EN defined, irq_o SHALL be registered and equal IRQ_EN & (RX_NE | OVERRUN | UNDERRUN); without it, irq_o SHALL be tied to 0 and CTRL bit9 SHALL read 0.

Structure
REQ-027 Register offsets, CTRL/STATUS bit indices and reset values SHALL live in package spi_slv_pkg (SPI_SLV_REG_* constants).
REQ-028 The RX FIFO SHALL be the sub-module spi_slv_fifo (sync, parameterized width/depth, level output).

Verification
REQ-029 Mode 0, TX=0xA5 preloaded, master sends 0x3C -> RX reads 0x3C, master receives 0xA5, TX_EMPTY=1.
REQ-030 Mode 3, no TX write, master sends two bytes -> master receives 0xFF,0xFF, UNDERRUN=1, W1C write 0x10 clears it.
REQ-031 Five bytes with no reads (RX_DEPTH=4) -> level=4, OVERRUN=1, reads return bytes 1-4 in order.
REQ-032 CS deasserted after 5 bits, then a full 0x81 frame -> only 0x81 in FIFO, no flags set.
REQ-033 SPI_SLV_IRQ_EN defined, IRQ_EN=1, one byte received -> irq_o rises and falls after the RX read empties the FIFO; macro undefined -> irq_o stays 0.
REQ-034 rst_n asserted mid-frame -> all REQ-025 values hold on the next clk, and the next full frame is received correctly.
